// File: rtl/mips_fetch_queue.sv
// Instruction fetch queue for a MIPS-style front end.
// It issues word-aligned fetches under a credit limit, buffers in-order responses and flushes on redirect.
`timescale 1ns/1ps

module mips_fetch_queue #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req_valid,
    output logic [ADDR_W-1:0]        imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_resp_valid,
    input  logic [31:0]              imem_resp_inst,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    input  logic                     halt,
    output logic                     inst_valid,
    output logic [31:0]              inst,
    output logic [ADDR_W-1:0]        inst_pc,
    input  logic                     inst_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] START_PC = RESET_PC & ~ADDR_W'(3);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop_cnt;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic [31:0]       inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic [CNT_W:0]    credit_used;
    logic [ADDR_W-1:0] redirect_target;
    logic              req_fire;
    logic              resp_take;
    logic              resp_push;
    logic              pop;

    // Queued entries plus in-flight requests may never exceed DEPTH, so every response has a slot.
    assign credit_used     = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid  = !rst && !halt && !redirect_valid
                             && (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_req_addr   = fetch_pc;
    assign req_fire        = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are strays from before a reset and are ignored.
    assign resp_take       = imem_resp_valid && (outstanding != '0);
    assign resp_push       = resp_take && (drop_cnt == '0) && !redirect_valid;

    assign inst_valid      = !rst && (count != '0) && !redirect_valid;
    assign pop             = inst_valid && inst_ready;
    assign inst            = inst_mem[rd_ptr];
    assign inst_pc         = pc_mem[rd_ptr];
    assign occupancy       = count;
    assign redirect_target = redirect_pc & ~ADDR_W'(3);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= START_PC;
            resp_pc     <= START_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight belongs to the old path and must be discarded on arrival.
            fetch_pc    <= redirect_target;
            resp_pc     <= redirect_target;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= outstanding - CNT_W'(resp_take);
            drop_cnt    <= outstanding - CNT_W'(resp_take);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(resp_take);
            if (resp_take && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            if (resp_push) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                resp_pc <= resp_pc + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(resp_push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && resp_push) begin
            inst_mem[wr_ptr] <= imem_resp_inst;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

endmodule
